// File: rtl/gh_ctrl_pkg.sv
// Shared types and encodings for the gigaHurt multicycle controller.
// States, opcode/funct values, ALU control codes and mux select encodings.
package gh_ctrl_pkg;

    localparam int N       = 16;
    localparam int TIMEOUT = 255;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPE,
        S_ALUWB,
        S_ADDIEX,
        S_ADDIWB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_AND = 3'b010;
    localparam logic [2:0] F_OR  = 3'b011;
    localparam logic [2:0] F_SLT = 3'b100;
    localparam logic [2:0] F_NOR = 3'b101;

    localparam logic [3:0] ALUCTL_AND = 4'b0000;
    localparam logic [3:0] ALUCTL_OR  = 4'b0001;
    localparam logic [3:0] ALUCTL_ADD = 4'b0010;
    localparam logic [3:0] ALUCTL_SUB = 4'b0110;
    localparam logic [3:0] ALUCTL_SLT = 4'b0111;
    localparam logic [3:0] ALUCTL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ALUOP_NONE,
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    localparam logic [1:0] ASRCB_B     = 2'b00;
    localparam logic [1:0] ASRCB_TWO   = 2'b01;
    localparam logic [1:0] ASRCB_IMM   = 2'b10;
    localparam logic [1:0] ASRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU-op class and R-type funct to a 4-bit ALU control code.
// The illegal flag reflects funct alone so the FSM can reject bad R-types.
module alu_decoder
    import gh_ctrl_pkg::*;
(
    input  logic [2:0] funct,
    input  aluop_t     aluop,
    output logic [3:0] alucontrol,
    output logic       illegal
);

    logic [3:0] w_fn_ctl;

    always_comb begin
        w_fn_ctl = ALUCTL_AND;
        illegal  = 1'b0;
        case (funct)
            F_ADD:   w_fn_ctl = ALUCTL_ADD;
            F_SUB:   w_fn_ctl = ALUCTL_SUB;
            F_AND:   w_fn_ctl = ALUCTL_AND;
            F_OR:    w_fn_ctl = ALUCTL_OR;
            F_SLT:   w_fn_ctl = ALUCTL_SLT;
            F_NOR:   w_fn_ctl = ALUCTL_NOR;
            default: illegal  = 1'b1;
        endcase
    end

    always_comb begin
        alucontrol = ALUCTL_AND;
        case (aluop)
            ALUOP_ADD:   alucontrol = ALUCTL_ADD;
            ALUOP_SUB:   alucontrol = ALUCTL_SUB;
            ALUOP_FUNCT: alucontrol = w_fn_ctl;
            default:     alucontrol = ALUCTL_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the 16-bit gigaHurt datapath.
// Sequences fetch/decode/execute and waits on the unified memory handshake.
module multicycle_controller
    import gh_ctrl_pkg::*;
#(
    parameter int n       = N,
    parameter int TIMEOUT = gh_ctrl_pkg::TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] instr,
    input  logic         zero,
    input  logic         mem_ready,
    output logic         mem_req,
    output logic         memwrite,
    output logic         iord,
    output logic         irwrite,
    output logic         pcwrite,
    output logic         pcen,
    output logic         regwrite,
    output logic         regdst,
    output logic         memtoreg,
    output logic         alusrca,
    output logic [1:0]   alusrcb,
    output logic [1:0]   pcsrc,
    output logic [3:0]   alucontrol,
    output logic         halted,
    output logic         err
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic       r_err;
    logic       w_set_err;

    logic [3:0] w_op;
    logic [2:0] w_funct;
    logic       w_illegal;
    logic       w_mem_st;
    logic       w_timeout;
    logic       w_unused;

    logic       w_mem_req;
    logic       w_memwrite;
    logic       w_iord;
    logic       w_irwrite;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_regwrite;
    logic       w_regdst;
    logic       w_memtoreg;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_pcsrc;
    aluop_t     w_aluop;
    logic [3:0] w_aluctl;

    assign w_op     = instr[n-1 -: 4];
    assign w_funct  = instr[2:0];
    assign w_unused = &{1'b0, instr[n-5:3]};

    assign w_mem_st  = is_mem_state(r_state);
    assign w_timeout = w_mem_st && !mem_ready
                    && (r_cnt == 8'(TIMEOUT - 1));

    alu_decoder u_alu_dec (
        .funct      (w_funct),
        .aluop      (w_aluop),
        .alucontrol (w_aluctl),
        .illegal    (w_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= r_err | w_set_err;
            if (w_mem_st && !mem_ready && (w_next == r_state))
                r_cnt <= r_cnt + 8'd1;
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        if (w_timeout) begin
            w_next    = S_HALT;
            w_set_err = 1'b1;
        end else begin
            unique case (r_state)
                S_FETCH:  if (mem_ready) w_next = S_DECODE;
                S_DECODE: begin
                    case (w_op)
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_RTYPE:     w_next = S_RTYPE;
                        OP_BEQ:       w_next = S_BRANCH;
                        OP_ADDI:      w_next = S_ADDIEX;
                        OP_J:         w_next = S_JUMP;
                        OP_HALT:      w_next = S_HALT;
                        default: begin
                            w_next    = S_FETCH;
                            w_set_err = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: w_next = (w_op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
                S_MEMWR:  if (mem_ready) w_next = S_FETCH;
                S_RTYPE: begin
                    w_next    = w_illegal ? S_FETCH : S_ALUWB;
                    w_set_err = w_illegal;
                end
                S_ADDIEX: w_next = S_ADDIWB;
                S_HALT:   w_next = S_HALT;
                default:  w_next = S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_mem_req  = 1'b0;
        w_memwrite = 1'b0;
        w_iord     = 1'b0;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_regwrite = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = ASRCB_B;
        w_pcsrc    = PCSRC_ALU;
        w_aluop    = ALUOP_NONE;
        unique case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_alusrcb = ASRCB_TWO;
                w_aluop   = ALUOP_ADD;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE: begin
                w_alusrcb = ASRCB_IMMSH;
                w_aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = ASRCB_IMM;
                w_aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            S_MEMWR: begin
                w_mem_req  = 1'b1;
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
            end
            // ALU inputs held through ALUWB so ALUOut stays stable
            S_RTYPE, S_ALUWB: begin
                w_alusrca  = 1'b1;
                w_aluop    = ALUOP_FUNCT;
                w_regwrite = (r_state == S_ALUWB);
                w_regdst   = (r_state == S_ALUWB);
            end
            S_ADDIWB: w_regwrite = 1'b1;
            S_BRANCH: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_SUB;
                w_branch  = 1'b1;
                w_pcsrc   = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                w_pcsrc   = PCSRC_JUMP;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes drop asynchronously while reset is held low
    assign mem_req    = reset & w_mem_req;
    assign memwrite   = reset & w_memwrite;
    assign iord       = reset & w_iord;
    assign irwrite    = reset & w_irwrite;
    assign pcwrite    = reset & w_pcwrite;
    assign pcen       = reset & (w_pcwrite | (w_branch & zero));
    assign regwrite   = reset & w_regwrite;
    assign regdst     = reset & w_regdst;
    assign memtoreg   = reset & w_memtoreg;
    assign alusrca    = reset & w_alusrca;
    assign alusrcb    = reset ? w_alusrcb : 2'b00;
    assign pcsrc      = reset ? w_pcsrc : 2'b00;
    assign alucontrol = reset ? w_aluctl : 4'b0000;
    assign halted     = (r_state == S_HALT);
    assign err        = r_err;

endmodule
